// File: rtl/serial_div.sv
// ---------------------------------------------------------------------------
// serial_div
//
// Bit-serial restoring divider. A 2*width-bit unsigned dividend and a
// width-bit unsigned divisor arrive on two independent valid/ready channels.
// The unit then produces a width-bit quotient and a width-bit remainder, one
// quotient bit per cycle, MSB first. The result is returned on a single
// valid/ready output channel.
//
// Handshake rule, applied to every channel: a transfer happens on the rising
// edge where valid and ready are both 1. A producer holds its data stable
// while valid=1 and ready=0. Ready may depend on state only, never on the
// partner's valid.
//
// Ports
//   clk            clock, all state on the rising edge
//   asyn_reset     asynchronous, active-high reset
//   dividend       [2*width-1:0] numerator, unsigned
//   dividend_vld   dividend valid
//   dividend_rdy   dividend ready (IDLE and dividend not yet captured)
//   divisor        [width-1:0] denominator, unsigned
//   divisor_vld    divisor valid
//   divisor_rdy    divisor ready (IDLE and divisor not yet captured)
//   quotient       [width-1:0] registered quotient
//   remainder      [width-1:0] registered remainder
//   div_err        registered divide-by-zero / quotient-overflow flag
//   d_out_vld      result valid (state DONE)
//   d_out_rdy      downstream ready
//   dbg_state_o    [1:0] current FSM state (0 IDLE, 1 COMP, 2 DONE)
// ---------------------------------------------------------------------------
module serial_div #(
  parameter int width = 128
) (
  input  logic                 clk,
  input  logic                 asyn_reset,
  input  logic [2*width-1:0]   dividend,
  input  logic                 dividend_vld,
  output logic                 dividend_rdy,
  input  logic [width-1:0]     divisor,
  input  logic                 divisor_vld,
  output logic                 divisor_rdy,
  output logic [width-1:0]     quotient,
  output logic [width-1:0]     remainder,
  output logic                 div_err,
  output logic                 d_out_vld,
  input  logic                 d_out_rdy,
  output logic [1:0]           dbg_state_o
);

  localparam int CNT_W = (width > 1) ? $clog2(width) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COMP = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic                 dvd_flag_q, dvd_flag_d;
  logic                 dvs_flag_q, dvs_flag_d;
  logic [2*width-1:0]   dvd_q, dvd_d;
  logic [width-1:0]     dvs_q, dvs_d;
  // Partial remainder. The algorithm keeps R < divisor at all times, so the
  // top bit of a (width+1)-bit R is always zero and is not stored.
  logic [width-1:0]     r_q, r_d;
  logic [width-1:0]     lo_q, lo_d;
  logic [width-1:0]     qsh_q, qsh_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [width-1:0]     quo_q, quo_d;
  logic [width-1:0]     rem_q, rem_d;
  logic                 err_q, err_d;

  // Handshake / operand selection
  logic                 cap_dvd, cap_dvs, complete, op_err;
  logic [2*width-1:0]   dvd_eff;
  logic [width-1:0]     dvs_eff;

  // One restoring step
  logic [width:0]       s_val;
  logic                 s_ge;
  logic [width-1:0]     s_diff;

  // Ready is forced low during reset so that no handshake can appear to
  // complete while the state is held cleared.
  assign dividend_rdy = ~asyn_reset & (state_q == IDLE) & ~dvd_flag_q;
  assign divisor_rdy  = ~asyn_reset & (state_q == IDLE) & ~dvs_flag_q;

  assign cap_dvd  = dividend_vld & dividend_rdy;
  assign cap_dvs  = divisor_vld  & divisor_rdy;
  assign complete = (dvd_flag_q | cap_dvd) & (dvs_flag_q | cap_dvs);

  // An operand captured on this edge has not reached its register yet.
  assign dvd_eff  = cap_dvd ? dividend : dvd_q;
  assign dvs_eff  = cap_dvs ? divisor  : dvs_q;

  // A quotient fits in width bits only if the high half is below the divisor.
  assign op_err   = (dvs_eff == '0) || (dvd_eff[2*width-1:width] >= dvs_eff);

  assign s_val    = {r_q, lo_q[width-1]};
  assign s_ge     = (s_val >= {1'b0, dvs_q});
  // S < 2*divisor, so S - divisor < divisor and the low width bits are exact.
  assign s_diff   = s_val[width-1:0] - dvs_q;

  always_comb begin
    state_d    = state_q;
    dvd_flag_d = dvd_flag_q;
    dvs_flag_d = dvs_flag_q;
    dvd_d      = dvd_q;
    dvs_d      = dvs_q;
    r_d        = r_q;
    lo_d       = lo_q;
    qsh_d      = qsh_q;
    cnt_d      = cnt_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    err_d      = err_q;

    case (state_q)
      IDLE: begin
        if (cap_dvd) begin
          dvd_flag_d = 1'b1;
          dvd_d      = dividend;
        end
        if (cap_dvs) begin
          dvs_flag_d = 1'b1;
          dvs_d      = divisor;
        end
        if (complete) begin
          dvd_flag_d = 1'b0;
          dvs_flag_d = 1'b0;
          if (op_err) begin
            state_d = DONE;
            err_d   = 1'b1;
            quo_d   = '1;
            rem_d   = '0;
          end else begin
            state_d = COMP;
            err_d   = 1'b0;
            r_d     = dvd_eff[2*width-1:width];
            lo_d    = dvd_eff[width-1:0];
            qsh_d   = '0;
            cnt_d   = '0;
          end
        end
      end

      COMP: begin
        r_d   = s_ge ? s_diff : s_val[width-1:0];
        lo_d  = {lo_q[width-2:0], 1'b0};
        qsh_d = {qsh_q[width-2:0], s_ge};
        cnt_d = cnt_q + 1'b1;
        // Last of the width steps: publish the result in the same edge.
        if (cnt_q == CNT_W'(width - 1)) begin
          state_d = DONE;
          quo_d   = qsh_d;
          rem_d   = r_d;
        end
      end

      DONE: begin
        if (d_out_rdy) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge asyn_reset) begin
    if (asyn_reset) begin
      state_q    <= IDLE;
      dvd_flag_q <= 1'b0;
      dvs_flag_q <= 1'b0;
      dvd_q      <= '0;
      dvs_q      <= '0;
      r_q        <= '0;
      lo_q       <= '0;
      qsh_q      <= '0;
      cnt_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      dvd_flag_q <= dvd_flag_d;
      dvs_flag_q <= dvs_flag_d;
      dvd_q      <= dvd_d;
      dvs_q      <= dvs_d;
      r_q        <= r_d;
      lo_q       <= lo_d;
      qsh_q      <= qsh_d;
      cnt_q      <= cnt_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      err_q      <= err_d;
    end
  end

  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_err     = err_q;
  assign d_out_vld   = (state_q == DONE);
  assign dbg_state_o = state_q;

endmodule

// File: doc/serial_div.md
# serial_div

Bit-serial restoring divider: the inverse of the team's serial shift-add multiplier. It takes a 2·width-bit dividend and a width-bit divisor over two independent valid/ready input channels. It produces a width-bit quotient and a width-bit remainder over one valid/ready output channel, one quotient bit per cycle, MSB first. It sits beside the multiplier in the fixed-point datapath and uses the same handshake, so either unit can feed the other.

## Interface
- width, default 128, operand width; dividend is 2·width, divisor/quotient/remainder are width.
- clk  input  1  clock, all state on rising edge.
- asyn_reset  input  1  reset, asynchronous, active-high.
- dividend  input  2·width  numerator, unsigned.
- dividend_vld  input  1  dividend valid.
- dividend_rdy  output  1  dividend ready.
- divisor  input  width  denominator, unsigned.
- divisor_vld  input  1  divisor valid.
- divisor_rdy  output  1  divisor ready.
- quotient  output  width  result quotient, registered.
- remainder  output  width  result remainder, registered.
- div_err  output  1  divide-by-zero or quotient overflow, registered.
- d_out_vld  output  1  result valid.
- d_out_rdy  input  1  downstream ready.

## Operation
- States: IDLE, COMP, DONE. Reset state is IDLE.
- **IDLE**
  - dividend_rdy = 1 while the dividend is not yet captured; divisor_rdy = 1 while the divisor is not yet captured. Both are decoded from state and capture flags.
  - Each channel captures on the edge where vld && rdy. Its flag then sets and its rdy drops.
  - Channels are independent: either order, or the same cycle.
- **Completion edge:** the edge on which the second operand is captured, or both in the same cycle.
  - Flags clear.
  - Check for error: divisor == 0 or dividend[2w-1:w] >= divisor.
  - Error case: go directly to DONE. div_err=1, quotient = all ones, remainder = 0.
  - Otherwise: go to COMP. Load partial remainder R (width+1 bits) = {0, dividend[2w-1:w]}, the low-half shift register = dividend[w-1:0], counter = 0, div_err=0.
- **COMP:** exactly width cycles. Each edge does:
  - S = {R[w-1:0], low-half MSB}; shift the low half left by 1.
  - If S >= divisor, R = S − divisor and shift 1 into the quotient LSB; otherwise R = S and shift 0.
  - Counter increments. On the edge where the counter reaches width−1, go to DONE and register remainder = R[w-1:0].
- **Width rule:** R < divisor always holds, so S < 2·divisor fits in width+1 bits. No precision is lost.
- **DONE:** d_out_vld = 1; quotient, remainder and div_err are stable.
  - On the edge with d_out_vld && d_out_rdy, go to IDLE.
  - Outputs hold their last values until the next result is written.
- No input is accepted during COMP or DONE: both rdy = 0.

## Timing
- Reset values:
  - Outputs: d_out_vld=0, quotient=0, remainder=0, div_err=0.
  - dividend_rdy and divisor_rdy are forced 0 while asyn_reset is high. They go to 1 in the first IDLE cycle after release.
  - Internal: flags, counter and R are 0.
- Latency, normal case: d_out_vld rises width edges after the completion edge, i.e. width+1 cycles from the cycle the last operand handshakes.
- Latency, error case: d_out_vld rises on the completion edge itself.
- Output backpressure: the result holds indefinitely while d_out_rdy=0. d_out_rdy asserted before d_out_vld is allowed.
- Accepted output: d_out_vld is low the cycle after the accepting edge, and both rdy are high the same cycle. This gives a minimum of 2 cycles between results plus the compute latency.
- Reset mid-operation (any state): immediate return to IDLE, all registers cleared, any partial result discarded, no d_out_vld pulse.
- Unhandshaken input values are ignored. Only the captured values are used.

## Test plan
All scenarios run with width=8 unless stated.
- **Basic divide:** dividend 16'd100 and divisor 8'd7 presented in the same cycle, d_out_rdy=1.
  - -> quotient 14, remainder 2, div_err 0.
  - d_out_vld rises exactly 9 cycles after the handshake cycle and stays high 1 cycle.
- **Maximum non-overflow:** dividend 16'hFEFF, divisor 8'hFF, with the divisor arriving 3 cycles after the dividend.
  - -> quotient 255, remainder 254.
  - dividend_rdy is low while waiting for the divisor.
- **Error cases:**
  - Divisor 0 with dividend 16'd55 -> div_err 1, quotient 8'hFF, remainder 0, d_out_vld on the cycle after the handshake.
  - Dividend 16'h0500 with divisor 5 -> the same error response.
- **Backpressure and back-to-back:** d_out_rdy held 0 for 5 cycles after the result is valid.
  - -> outputs stable and both rdy low throughout.
  - On release, the next operand pair (16'd1000 / 8'd33) gives quotient 30, remainder 10.
- **Reset in COMP:** assert asyn_reset at counter=4.
  - -> all outputs 0 immediately, no d_out_vld.
  - After release, 16'd81 / 8'd9 gives quotient 9, remainder 0.
- **Default width=128:** random 256-bit dividend with its high half below a random nonzero divisor.
  - -> quotient·divisor + remainder == dividend and remainder < divisor.
  - Latency is 129 cycles.
